// File: rtl/avm_master_arbiter_pkg.sv
// Shared definitions for the two-requester Avalon-MM master arbiter.
// State encodings and the default hold limit for locked grants.
package avm_master_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/avm_arb_mux.sv
// Grant-selected combinational steering between two requesters and one Avalon-MM master.
// Only the owner's strobes reach the master; everyone else sees waitrequest and zero data.
module avm_arb_mux #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [1:0]               grant,
    input  logic [ADDRESS_WIDTH-1:0] r0_address,
    input  logic                     r0_read,
    input  logic                     r0_write,
    input  logic [DATA_WIDTH-1:0]    r0_writedata,
    input  logic [ADDRESS_WIDTH-1:0] r1_address,
    input  logic                     r1_read,
    input  logic                     r1_write,
    input  logic [DATA_WIDTH-1:0]    r1_writedata,
    input  logic                     m_waitrequest,
    input  logic [DATA_WIDTH-1:0]    m_readdata,
    output logic [ADDRESS_WIDTH-1:0] m_address,
    output logic                     m_read,
    output logic                     m_write,
    output logic [DATA_WIDTH-1:0]    m_writedata,
    output logic [DATA_WIDTH-1:0]    r0_readdata,
    output logic                     r0_waitrequest,
    output logic [DATA_WIDTH-1:0]    r1_readdata,
    output logic                     r1_waitrequest
);

    always_comb begin
        m_address      = '0;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_writedata    = '0;
        r0_readdata    = '0;
        r0_waitrequest = 1'b1;
        r1_readdata    = '0;
        r1_waitrequest = 1'b1;
        case (grant)
            2'b01: begin
                m_address      = r0_address;
                m_read         = r0_read;
                m_write        = r0_write;
                m_writedata    = r0_writedata;
                r0_readdata    = m_readdata;
                r0_waitrequest = m_waitrequest;
            end
            2'b10: begin
                m_address      = r1_address;
                m_read         = r1_read;
                m_write        = r1_write;
                m_writedata    = r1_writedata;
                r1_readdata    = m_readdata;
                r1_waitrequest = m_waitrequest;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/avm_master_arbiter.sv
// Two-requester Avalon-MM arbiter: registered grant FSM, alternating tie-break, optional lock.
// Define AVM_ARB_LOCK_EN to honour Rn_LOCK with a MAX_HOLD-bounded hold counter.
module avm_master_arbiter
    import avm_master_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MAX_HOLD      = DEFAULT_MAX_HOLD
) (
    input  logic                     CSI_CLOCK_CLK,
    input  logic                     CSI_CLOCK_RESET,
    input  logic [ADDRESS_WIDTH-1:0] R0_ADDRESS,
    input  logic                     R0_READ,
    input  logic                     R0_WRITE,
    input  logic [DATA_WIDTH-1:0]    R0_WRITEDATA,
    input  logic                     R0_LOCK,
    output logic [DATA_WIDTH-1:0]    R0_READDATA,
    output logic                     R0_WAITREQUEST,
    input  logic [ADDRESS_WIDTH-1:0] R1_ADDRESS,
    input  logic                     R1_READ,
    input  logic                     R1_WRITE,
    input  logic [DATA_WIDTH-1:0]    R1_WRITEDATA,
    input  logic                     R1_LOCK,
    output logic [DATA_WIDTH-1:0]    R1_READDATA,
    output logic                     R1_WAITREQUEST,
    output logic [ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
    output logic                     AVM_AVALONMASTER_READ,
    output logic                     AVM_AVALONMASTER_WRITE,
    output logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA,
    input  logic                     AVM_AVALONMASTER_WAITREQUEST,
    input  logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
    output logic [1:0]               GRANT
);

    arb_state_t state_reg, state_next;
    logic       last_grant_reg;   // 1 = R1 owned last, so R0 wins the next tie
    logic       armed_reg;        // blocks granting on the first edge after reset
    logic       req0, req1, own_req, other_req, granted, done;
    logic       hold_ok, idle_lock;
    arb_state_t other_state;

    assign req0    = R0_READ | R0_WRITE;
    assign req1    = R1_READ | R1_WRITE;
    assign granted = (state_reg != IDLE);
    assign GRANT   = {state_reg == GRANT1, state_reg == GRANT0};

`ifdef AVM_ARB_LOCK_EN
    logic [7:0] hold_cnt_reg;
    logic       own_lock;
    assign own_lock  = (state_reg == GRANT1) ? R1_LOCK : R0_LOCK;
    assign hold_ok   = own_lock && ((int'(hold_cnt_reg) + 1) < MAX_HOLD);
    assign idle_lock = own_lock;
`else
    logic unused_cfg;
    assign unused_cfg = R0_LOCK ^ R1_LOCK ^ (MAX_HOLD > 0);
    assign hold_ok    = 1'b0;
    assign idle_lock  = 1'b0;
`endif

    always_comb begin
        own_req     = (state_reg == GRANT1) ? req1 : req0;
        other_req   = (state_reg == GRANT1) ? req0 : req1;
        other_state = (state_reg == GRANT1) ? GRANT0 : GRANT1;
        done        = granted && own_req && !AVM_AVALONMASTER_WAITREQUEST;
        state_next  = state_reg;
        case (state_reg)
            IDLE: begin
                if (armed_reg) begin
                    if (req0 && req1)
                        state_next = last_grant_reg ? GRANT0 : GRANT1;
                    else if (req0)
                        state_next = GRANT0;
                    else if (req1)
                        state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // A stalled owner keeps the grant: a switch needs a completion or an idle owner.
                if (own_req) begin
                    if (done && other_req && !hold_ok)
                        state_next = other_state;
                end else if (!idle_lock) begin
                    state_next = other_req ? other_state : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET) begin
        if (!CSI_CLOCK_RESET) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            armed_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
            if (state_next != state_reg) begin
                if (state_next == GRANT0)
                    last_grant_reg <= 1'b0;
                else if (state_next == GRANT1)
                    last_grant_reg <= 1'b1;
            end
        end
    end

`ifdef AVM_ARB_LOCK_EN
    always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET) begin
        if (!CSI_CLOCK_RESET)
            hold_cnt_reg <= 8'd0;
        else if (state_next != state_reg)
            hold_cnt_reg <= 8'd0;
        else if (done && (int'(hold_cnt_reg) < MAX_HOLD))
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
    end
`endif

    avm_arb_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_mux (
        .grant         (GRANT),
        .r0_address    (R0_ADDRESS),
        .r0_read       (R0_READ),
        .r0_write      (R0_WRITE),
        .r0_writedata  (R0_WRITEDATA),
        .r1_address    (R1_ADDRESS),
        .r1_read       (R1_READ),
        .r1_write      (R1_WRITE),
        .r1_writedata  (R1_WRITEDATA),
        .m_waitrequest (AVM_AVALONMASTER_WAITREQUEST),
        .m_readdata    (AVM_AVALONMASTER_READDATA),
        .m_address     (AVM_AVALONMASTER_ADDRESS),
        .m_read        (AVM_AVALONMASTER_READ),
        .m_write       (AVM_AVALONMASTER_WRITE),
        .m_writedata   (AVM_AVALONMASTER_WRITEDATA),
        .r0_readdata   (R0_READDATA),
        .r0_waitrequest(R0_WAITREQUEST),
        .r1_readdata   (R1_READDATA),
        .r1_waitrequest(R1_WAITREQUEST)
    );

endmodule

// File: doc/avm_master_arbiter.md
AVM_MASTER_ARBITER -- requirements
Module: avm_master_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of all data buses.
REQ-002 Parameter: ADDRESS_WIDTH, 32, width of all address buses.
REQ-003 Parameter: MAX_HOLD, 8, maximum consecutive completed transfers per locked grant while the other requester waits (range 1..255).
REQ-004 CSI_CLOCK_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 CSI_CLOCK_RESET  in  1  asynchronous, active-low reset.
REQ-006 Rn_ADDRESS  in  ADDRESS_WIDTH  requester n address (n = 0, 1 on every Rn_ port).
REQ-007 Rn_READ, Rn_WRITE  in  1 each  requester n read/write strobes (never both high).
REQ-008 Rn_WRITEDATA  in  DATA_WIDTH  requester n write data.
REQ-009 Rn_LOCK  in  1  requester n asks to keep the grant across transfers.
REQ-010 Rn_READDATA  out  DATA_WIDTH  read data to requester n.
REQ-011 Rn_WAITREQUEST  out  1  stall to requester n.
REQ-012 AVM_AVALONMASTER_ADDRESS/READ/WRITE/WRITEDATA  out  ADDRESS_WIDTH/1/1/DATA_WIDTH  shared Avalon-MM master.
REQ-013 AVM_AVALONMASTER_WAITREQUEST  in  1; AVM_AVALONMASTER_READDATA  in  DATA_WIDTH.
REQ-014 GRANT  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-015 FSM states IDLE, GRANT0, GRANT1; the grant is registered, and master outputs are a combinational mux of the granted requester's inputs.
REQ-016 Rn_req = Rn_READ | Rn_WRITE; a transfer completes on a cycle where the granted Rn_req is high and AVM_AVALONMASTER_WAITREQUEST is low.
REQ-017 IDLE: only R0_req -> GRANT0; only R1_req -> GRANT1; both -> the requester opposite the last_grant register; none -> stay.
REQ-018 Arbitration latency is exactly one cycle: a request seen in IDLE appears on the master port the next cycle.
REQ-019 Non-granted requester: Rn_WAITREQUEST = 1 and Rn_READDATA = 0.
REQ-020 Granted requester: Rn_WAITREQUEST = AVM_AVALONMASTER_WAITREQUEST, and Rn_READDATA = AVM_AVALONMASTER_READDATA.
REQ-021 In IDLE, AVM READ/WRITE = 0, ADDRESS = 0, WRITEDATA = 0.
REQ-022 Grant never changes while the owner has a transfer stalled by waitrequest.
REQ-023 hold_cnt (8 bit) increments on each completed transfer, clears on every grant change, and saturates at MAX_HOLD.
REQ-024 At a completion in GRANTx with Ry_req high: if Rx_LOCK is high and hold_cnt+1 < MAX_HOLD, stay; otherwise go directly to GRANTy.
REQ-025 In GRANTx with Rx_req low and Rx_LOCK low: if Ry_req is high go to GRANTy, else go to IDLE; if Rx_LOCK is high, stay with no bus activity.
REQ-026 In GRANTx with Rx_req high and Ry_req low: stay granted indefinitely.
REQ-027 last_grant updates on every entry to GRANT0 or GRANT1.

Reset
REQ-028 Reset asserted (even mid-transfer): state IDLE, GRANT = 0, hold_cnt = 0, last_grant = 1 so R0 wins the first tie, and all master strobes deassert immediately.
REQ-029 After reset deasserts, the first grant occurs no earlier than the second rising edge.

Configuration
REQ-030 Macro AVM_ARB_LOCK_EN: when defined, REQ-009, REQ-023, REQ-024 and the lock terms of REQ-025 apply.
REQ-031 Without AVM_ARB_LOCK_EN, Rn_LOCK is ignored, hold_cnt is absent, and each completion with the other requester waiting switches the grant (strict alternation).

Structure
REQ-032 A shared package holds the state encodings (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the default MAX_HOLD.
REQ-033 A single sub-module, avm_arb_mux, implements the grant-selected combinational port mux; the FSM and counters live in the top module.

Verification
REQ-034 Both requesters read at the same cycle after reset -> R0 granted the next cycle, R1 after R0 completes, with GRANT = 01 then 10.
REQ-035 R0 writes 0xDEADBEEF to 0x100 while master waitrequest is held for 3 cycles -> master outputs stay stable, GRANT stays 01, R1_WAITREQUEST = 1 throughout.
REQ-036 With lock enabled and MAX_HOLD=4, R0 locked issuing 10 reads while R1 is pending -> R1 granted after R0's 4th completion.
REQ-037 Without AVM_ARB_LOCK_EN, both requesters continuously request -> grants alternate 0,1,0,1 for 8 completions.
REQ-038 Reset asserted during an R1 stalled read -> READ drops asynchronously, GRANT = 00, and R0 wins the next tie.
REQ-039 R1 reads 0x200 with readdata 0x12345678 -> R1_READDATA = 0x12345678 on the completion cycle, and R0_READDATA = 0.
